// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: word-select encoding, FSM states and grant codes.
package CustomTypes;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } WordSelect;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INSTR_RD = 3'd1,
    DATA_RD  = 3'd2,
    DATA_WR  = 3'd3,
    RESP     = 3'd4
  } ArbState;

  typedef enum logic [1:0] {
    GntNone   = 2'd0,
    GntInstr  = 2'd1,
    GntDataRd = 2'd2,
    GntDataWr = 2'd3
  } ArbGrant;

  // Value of mem_source / rr_last for each requester.
  localparam logic SrcInstr = 1'b0;
  localparam logic SrcData  = 1'b1;

endpackage

// File: rtl/memory_arbiter_arb_select.sv
// Combinational grant logic for the memory arbiter.
// Build option ARBITER_RR_EN: alternate between sources on conflict using rr_last;
// otherwise data requests always beat instruction requests.
module arb_select
  import CustomTypes::*;
(
  input  logic    i_instr_req,
  input  logic    i_data_rd,
  input  logic    i_data_wr,
`ifdef ARBITER_RR_EN
  input  logic    i_rr_last,
`endif
  output ArbGrant o_grant
);

  logic w_data_req;
  logic w_data_wins;

  // Pick the winning source; a simultaneous data read+write resolves to the write.
  always_comb begin
    w_data_req = i_data_rd | i_data_wr;
`ifdef ARBITER_RR_EN
    w_data_wins = w_data_req & (~i_instr_req | (i_rr_last == SrcInstr));
`else
    w_data_wins = w_data_req;
`endif
    o_grant = GntNone;
    if (w_data_wins) begin
      o_grant = i_data_wr ? GntDataWr : GntDataRd;
    end else if (i_instr_req) begin
      o_grant = GntInstr;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbiter between the instruction and data caches and one 64-bit external memory port.
// Build option ARBITER_RR_EN: round-robin between sources when both request in IDLE.
module memory_arbiter
  import CustomTypes::*;
#(
  parameter int MEM_WIDTH  = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instr_address,
  input  logic                  instr_read,
  output logic [MEM_WIDTH-1:0]  instr_data,
  output logic                  instr_ready,
  input  logic [31:0]           data_address,
  input  logic                  data_read,
  input  logic                  data_write,
  input  WordSelect             data_ws,
  inout  wire [DATA_WIDTH-1:0]  data_data,
  output logic                  data_ready,
  output logic                  data_done,
  output logic [31:0]           mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_source,
  output WordSelect             mem_ws,
  inout  wire [MEM_WIDTH-1:0]   mem_data,
  input  logic                  mem_ready,
  input  logic                  mem_done
);

  ArbState                r_state;
  logic [31:0]            r_mem_address;
  logic                   r_mem_read;
  logic                   r_mem_write;
  logic                   r_mem_source;
  WordSelect              r_mem_ws;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic [MEM_WIDTH-1:0]   r_instr_data;
  logic                   r_instr_ready;
  logic                   r_data_ready;
  logic                   r_data_done;
  ArbGrant                w_grant;
  logic                   w_unused_instr_lsb;
`ifdef ARBITER_RR_EN
  logic                   r_rr_last;
`endif

  // Refills are always line-aligned, so the low address bits are dropped.
  assign w_unused_instr_lsb = ^instr_address[2:0];

  arb_select u_arb_select (
    .i_instr_req (instr_read),
    .i_data_rd   (data_read),
    .i_data_wr   (data_write),
`ifdef ARBITER_RR_EN
    .i_rr_last   (r_rr_last),
`endif
    .o_grant     (w_grant)
  );

  // Transaction FSM: grant in IDLE, hold the command until RAM completes, pulse in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_mem_address <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_source  <= SrcInstr;
      r_mem_ws      <= BYTE;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_instr_data  <= '0;
      r_instr_ready <= 1'b0;
      r_data_ready  <= 1'b0;
      r_data_done   <= 1'b0;
`ifdef ARBITER_RR_EN
      r_rr_last     <= SrcInstr;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          unique case (w_grant)
            GntInstr: begin
              r_mem_address <= {instr_address[31:3], 3'b000};
              r_mem_read    <= 1'b1;
              r_mem_source  <= SrcInstr;
              r_mem_ws      <= WORD;
              r_state       <= INSTR_RD;
`ifdef ARBITER_RR_EN
              r_rr_last     <= SrcInstr;
`endif
            end
            GntDataRd: begin
              r_mem_address <= data_address;
              r_mem_read    <= 1'b1;
              r_mem_source  <= SrcData;
              r_mem_ws      <= data_ws;
              r_state       <= DATA_RD;
`ifdef ARBITER_RR_EN
              r_rr_last     <= SrcData;
`endif
            end
            GntDataWr: begin
              r_mem_address <= data_address;
              r_mem_write   <= 1'b1;
              r_mem_source  <= SrcData;
              r_mem_ws      <= data_ws;
              r_wdata       <= data_data;
              r_state       <= DATA_WR;
`ifdef ARBITER_RR_EN
              r_rr_last     <= SrcData;
`endif
            end
            default: ;
          endcase
        end
        INSTR_RD: begin
          if (mem_ready) begin
            r_instr_data  <= mem_data;
            r_mem_read    <= 1'b0;
            r_instr_ready <= 1'b1;
            r_state       <= RESP;
          end
        end
        DATA_RD: begin
          if (mem_ready) begin
            // The RAM returns the whole aligned doubleword; address bit 2 picks the lane.
            r_rdata      <= r_mem_address[2] ? mem_data[MEM_WIDTH-1:DATA_WIDTH]
                                             : mem_data[DATA_WIDTH-1:0];
            r_mem_read   <= 1'b0;
            r_data_ready <= 1'b1;
            r_state      <= RESP;
          end
        end
        DATA_WR: begin
          if (mem_done) begin
            r_mem_write <= 1'b0;
            r_data_done <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          r_instr_ready <= 1'b0;
          r_data_ready  <= 1'b0;
          r_data_done   <= 1'b0;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_address = r_mem_address;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_source  = r_mem_source;
  assign mem_ws      = r_mem_ws;
  assign instr_data  = r_instr_data;
  assign instr_ready = r_instr_ready;
  assign data_ready  = r_data_ready;
  assign data_done   = r_data_done;

  // Write word goes out on both lanes; the RAM selects using address[2] and ws.
  assign mem_data  = r_mem_write  ? {r_wdata, r_wdata} : 'z;
  assign data_data = r_data_ready ? r_rdata : 'z;

endmodule
